regs_wb_arbiter: RTL and testbench

REGS_WB_ARBITER -- requirements
Module: regs_wb_arbiter

---
 rtl/regs_wb_arbiter_if.sv | 57 +++++
 rtl/regs_wb_arbiter.sv | 119 +++++++++++
 tb/tb_regs_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/regs_wb_arbiter_if.sv
// Bus bundle for regs_wb_arbiter: two writeback requesters, issue port, operand
// read/hazard/forward signals and the registered register-file write port.
interface regs_wb_arbiter_if;
   logic        req0_valid;
   logic        req0_ready;
   logic [4:0]  req0_addr;
   logic [31:0] req0_data;

   logic        req1_valid;
   logic        req1_ready;
   logic [4:0]  req1_addr;
   logic [31:0] req1_data;

   logic        iss_valid;
   logic [4:0]  iss_addr;
   logic        iss_ready;

   logic [4:0]  R_addr_A;
   logic [4:0]  R_addr_B;
   logic        hazard_A;
   logic        hazard_B;

   logic        L_S;
   logic [4:0]  Wt_addr;
   logic [31:0] Wt_data;

   logic        fwd_A_sel;
   logic        fwd_B_sel;
   logic [31:0] fwd_A;
   logic [31:0] fwd_B;

   modport slave (
      input  req0_valid, req0_addr, req0_data,
      output req0_ready,
      input  req1_valid, req1_addr, req1_data,
      output req1_ready,
      input  iss_valid, iss_addr,
      output iss_ready,
      input  R_addr_A, R_addr_B,
      output hazard_A, hazard_B,
      output L_S, Wt_addr, Wt_data,
      output fwd_A_sel, fwd_B_sel, fwd_A, fwd_B
   );

   modport master (
      output req0_valid, req0_addr, req0_data,
      input  req0_ready,
      output req1_valid, req1_addr, req1_data,
      input  req1_ready,
      output iss_valid, iss_addr,
      input  iss_ready,
      output R_addr_A, R_addr_B,
      input  hazard_A, hazard_B,
      input  L_S, Wt_addr, Wt_data,
      input  fwd_A_sel, fwd_B_sel, fwd_A, fwd_B
   );
endinterface

// File: rtl/regs_wb_arbiter.sv
// Round-robin writeback arbiter with register pending scoreboard.
// Optional macro WB_BYPASS_EN forwards the in-flight write data to the read operands.
module regs_wb_arbiter (
   input  logic               clk,
   input  logic               rst,
   regs_wb_arbiter_if.slave   bus_io
);

   logic        prio1_q, prio1_d;   // 1: req1 wins a tie
   logic        ls_q, ls_d;
   logic [4:0]  wt_addr_q, wt_addr_d;
   logic [31:0] wt_data_q, wt_data_d;
   logic [31:0] pend_q, pend_d;

   logic        gnt0, gnt1, xfer;
   logic [4:0]  xfer_addr;
   logic [31:0] xfer_data;
   logic        iss_ok, iss_fire;

   // Grant is gated by rst so no transfer can happen in a reset cycle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!rst) begin
         if (bus_io.req0_valid && bus_io.req1_valid) begin
            gnt0 = !prio1_q;
            gnt1 = prio1_q;
         end else begin
            gnt0 = bus_io.req0_valid;
            gnt1 = bus_io.req1_valid;
         end
      end
   end

   assign xfer      = gnt0 | gnt1;
   assign xfer_addr = gnt1 ? bus_io.req1_addr : bus_io.req0_addr;
   assign xfer_data = gnt1 ? bus_io.req1_data : bus_io.req0_data;

   assign bus_io.req0_ready = gnt0;
   assign bus_io.req1_ready = gnt1;

   // WAW stall: an address still awaiting its writeback cannot be re-issued.
   assign iss_ok           = !((bus_io.iss_addr != 5'd0) && pend_q[bus_io.iss_addr]);
   assign iss_fire         = bus_io.iss_valid && iss_ok && !rst;
   assign bus_io.iss_ready = iss_ok && !rst;

   always_comb begin
      prio1_d   = prio1_q;
      ls_d      = 1'b0;
      wt_addr_d = wt_addr_q;
      wt_data_d = wt_data_q;
      if (xfer) begin
         prio1_d   = gnt0;
         ls_d      = (xfer_addr != 5'd0);
         wt_addr_d = xfer_addr;
         wt_data_d = xfer_data;
      end
   end

   // Clear first, then set, so a same-edge issue to the retiring address survives.
   always_comb begin
      pend_d = pend_q;
      if (ls_q) begin
         pend_d[wt_addr_q] = 1'b0;
      end
      if (iss_fire && (bus_io.iss_addr != 5'd0)) begin
         pend_d[bus_io.iss_addr] = 1'b1;
      end
      pend_d[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio1_q   <= 1'b0;
         ls_q      <= 1'b0;
         wt_addr_q <= 5'd0;
         wt_data_q <= 32'd0;
         pend_q    <= 32'd0;
      end else begin
         prio1_q   <= prio1_d;
         ls_q      <= ls_d;
         wt_addr_q <= wt_addr_d;
         wt_data_q <= wt_data_d;
         pend_q    <= pend_d;
      end
   end

   assign bus_io.L_S     = ls_q;
   assign bus_io.Wt_addr = wt_addr_q;
   assign bus_io.Wt_data = wt_data_q;

   logic pend_a, pend_b;
   assign pend_a = (bus_io.R_addr_A != 5'd0) && pend_q[bus_io.R_addr_A];
   assign pend_b = (bus_io.R_addr_B != 5'd0) && pend_q[bus_io.R_addr_B];

`ifdef WB_BYPASS_EN
   logic byp_a, byp_b;
   assign byp_a = ls_q && (wt_addr_q == bus_io.R_addr_A) && (bus_io.R_addr_A != 5'd0);
   assign byp_b = ls_q && (wt_addr_q == bus_io.R_addr_B) && (bus_io.R_addr_B != 5'd0);

   assign bus_io.hazard_A  = pend_a && !byp_a;
   assign bus_io.hazard_B  = pend_b && !byp_b;
   assign bus_io.fwd_A_sel = byp_a;
   assign bus_io.fwd_B_sel = byp_b;
   assign bus_io.fwd_A     = byp_a ? wt_data_q : 32'd0;
   assign bus_io.fwd_B     = byp_b ? wt_data_q : 32'd0;
`else
   assign bus_io.hazard_A  = pend_a;
   assign bus_io.hazard_B  = pend_b;
   assign bus_io.fwd_A_sel = 1'b0;
   assign bus_io.fwd_B_sel = 1'b0;
   assign bus_io.fwd_A     = 32'd0;
   assign bus_io.fwd_B     = 32'd0;
`endif

   a_one_grant : assert property (@(posedge clk) !(bus_io.req0_ready && bus_io.req1_ready));
   a_pend_zero : assert property (@(posedge clk) disable iff (rst) !pend_q[0]);

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Self-checking bench for regs_wb_arbiter: directed scenarios then randomized traffic,
// all checked against a behavioural scoreboard model.
module tb_regs_wb_arbiter;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   regs_wb_arbiter_if bus ();

   regs_wb_arbiter dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   int n_cmp = 0;
   int n_err = 0;

   // Reference model state
   bit          m_pend[32];
   bit          m_ls;
   logic [4:0]  m_waddr;
   logic [31:0] m_wdata;
   int          m_last;     // requester granted most recently (1 after reset: req0 favoured)
   bit          m_g0, m_g1; // grants seen in the previous step

   task automatic check_eq(string tag, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      m_ls    = 1'b0;
      m_waddr = 5'd0;
      m_wdata = 32'd0;
      m_last  = 1;
   endtask

   function automatic bit model_byp(logic [4:0] a);
`ifdef WB_BYPASS_EN
      return m_ls && (m_waddr == a) && (a != 5'd0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic bit model_haz(logic [4:0] a);
      if (a == 5'd0) return 1'b0;
      if (model_byp(a)) return 1'b0;
      return m_pend[a];
   endfunction

   task automatic idle();
      bus.req0_valid = 1'b0; bus.req0_addr = 5'd0; bus.req0_data = 32'd0;
      bus.req1_valid = 1'b0; bus.req1_addr = 5'd0; bus.req1_data = 32'd0;
      bus.iss_valid  = 1'b0; bus.iss_addr  = 5'd0;
      bus.R_addr_A   = 5'd0; bus.R_addr_B  = 5'd0;
   endtask

   // Compare every output against the model, advance the model across the edge.
   task automatic step();
      bit          g0, g1, iok;
      logic [4:0]  a;
      logic [31:0] d;
      #2;
      g0  = 1'b0;
      g1  = 1'b0;
      iok = 1'b0;
      if (!rst) begin
         if (bus.req0_valid && bus.req1_valid) begin
            g0 = (m_last == 1);
            g1 = (m_last == 0);
         end else begin
            g0 = bus.req0_valid;
            g1 = bus.req1_valid;
         end
         iok = !((bus.iss_addr != 5'd0) && m_pend[bus.iss_addr]);
         check_eq("req0_ready", 32'(bus.req0_ready), 32'(g0));
         check_eq("req1_ready", 32'(bus.req1_ready), 32'(g1));
         check_eq("iss_ready", 32'(bus.iss_ready), 32'(iok));
      end
      check_eq("hazard_A", 32'(bus.hazard_A), 32'(model_haz(bus.R_addr_A)));
      check_eq("hazard_B", 32'(bus.hazard_B), 32'(model_haz(bus.R_addr_B)));
      check_eq("L_S", 32'(bus.L_S), 32'(m_ls));
      if (m_ls) begin
         check_eq("Wt_addr", 32'(bus.Wt_addr), 32'(m_waddr));
         check_eq("Wt_data", bus.Wt_data, m_wdata);
      end
      check_eq("fwd_A_sel", 32'(bus.fwd_A_sel), 32'(model_byp(bus.R_addr_A)));
      check_eq("fwd_B_sel", 32'(bus.fwd_B_sel), 32'(model_byp(bus.R_addr_B)));
      check_eq("fwd_A", bus.fwd_A, model_byp(bus.R_addr_A) ? m_wdata : 32'd0);
      check_eq("fwd_B", bus.fwd_B, model_byp(bus.R_addr_B) ? m_wdata : 32'd0);

      if (rst) begin
         model_reset();
      end else begin
         if (m_ls) m_pend[m_waddr] = 1'b0;
         if (iok && bus.iss_valid && (bus.iss_addr != 5'd0)) m_pend[bus.iss_addr] = 1'b1;
         if (g0 || g1) begin
            a       = g1 ? bus.req1_addr : bus.req0_addr;
            d       = g1 ? bus.req1_data : bus.req0_data;
            m_ls    = (a != 5'd0);
            m_waddr = a;
            m_wdata = d;
            m_last  = g1 ? 1 : 0;
         end else begin
            m_ls = 1'b0;
         end
      end
      m_g0 = g0;
      m_g1 = g1;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      idle();
      rst = 1'b1;
      @(posedge clk);
      #1;
      model_reset();
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      rst  = 1'b0;

      // Reset state
      check_eq("rst_L_S", 32'(bus.L_S), 32'd0);
      check_eq("rst_Wt_addr", 32'(bus.Wt_addr), 32'd0);
      check_eq("rst_Wt_data", bus.Wt_data, 32'd0);
      step();

      // Single req0 writeback
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd5; bus.req0_data = 32'hDEADBEEF;
      #1 check_eq("single_ready", 32'(bus.req0_ready), 32'd1);
      step();
      idle();
      check_eq("single_L_S", 32'(bus.L_S), 32'd1);
      check_eq("single_addr", 32'(bus.Wt_addr), 32'd5);
      check_eq("single_data", bus.Wt_data, 32'hDEADBEEF);
      step();
      check_eq("single_L_S_off", 32'(bus.L_S), 32'd0);

      // Round-robin with both requesters valid
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd3; bus.req0_data = 32'hA0A0_0003;
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd4; bus.req1_data = 32'hB1B1_0004;
      for (int i = 0; i < 4; i++) begin
         #1 check_eq("rr_grant0", 32'(bus.req0_ready), 32'((i % 2) == 0));
         if (i > 0) check_eq("rr_L_S", 32'(bus.L_S), 32'd1);
         step();
      end
      idle();
      check_eq("rr_L_S_last", 32'(bus.L_S), 32'd1);
      check_eq("rr_addr_last", 32'(bus.Wt_addr), 32'd4);
      step();

      // WAW stall and read hazard on address 7
      do_reset();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd7; bus.R_addr_A = 5'd7;
      #1 check_eq("waw_first_ready", 32'(bus.iss_ready), 32'd1);
      step();
      for (int i = 0; i < 2; i++) begin
         check_eq("waw_stall", 32'(bus.iss_ready), 32'd0);
         check_eq("waw_hazA", 32'(bus.hazard_A), 32'd1);
         step();
      end
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd7; bus.req0_data = 32'h0000_0077;
      step();
      bus.req0_valid = 1'b0;
      check_eq("waw_ls_stall", 32'(bus.iss_ready), 32'd0);
`ifdef WB_BYPASS_EN
      check_eq("waw_byp_haz", 32'(bus.hazard_A), 32'd0);
      check_eq("waw_byp_fwd", bus.fwd_A, 32'h0000_0077);
`else
      check_eq("waw_nobyp_haz", 32'(bus.hazard_A), 32'd1);
`endif
      bus.iss_valid = 1'b0;
      step();
      bus.iss_valid = 1'b1;
      #1 check_eq("waw_released", 32'(bus.iss_ready), 32'd1);
      check_eq("waw_hazA_clear", 32'(bus.hazard_A), 32'd0);
      bus.iss_valid = 1'b0;
      step();

      // Writeback to address 0
      idle();
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd0; bus.req1_data = 32'h0000_1234;
      #1 check_eq("zero_ready", 32'(bus.req1_ready), 32'd1);
      check_eq("zero_hazA", 32'(bus.hazard_A), 32'd0);
      step();
      idle();
      check_eq("zero_L_S", 32'(bus.L_S), 32'd0);
      check_eq("zero_hazA2", 32'(bus.hazard_A), 32'd0);
      step();

      // Same-edge set and clear of address 9
      do_reset();
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd9; bus.req0_data = 32'h0000_0099;
      step();
      idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
      #1 check_eq("setclr_ls", 32'(bus.L_S), 32'd1);
      check_eq("setclr_iss", 32'(bus.iss_ready), 32'd1);
      step();
      idle();
      bus.R_addr_A = 5'd9;
      #1 check_eq("setclr_pend", 32'(bus.hazard_A), 32'd1);
      step();

      // Reset with pending bits and a write in flight
      idle();
      bus.iss_valid = 1'b1; bus.iss_addr = 5'd12;
      step();
      idle();
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd13; bus.req0_data = 32'h0000_0013;
      step();
      idle();
      check_eq("rstfly_ls", 32'(bus.L_S), 32'd1);
      do_reset();
      bus.R_addr_A = 5'd12; bus.R_addr_B = 5'd9;
      bus.req0_valid = 1'b1; bus.req0_addr = 5'd1; bus.req0_data = 32'h1;
      bus.req1_valid = 1'b1; bus.req1_addr = 5'd2; bus.req1_data = 32'h2;
      #1 check_eq("rstfly_L_S", 32'(bus.L_S), 32'd0);
      check_eq("rstfly_hazA", 32'(bus.hazard_A), 32'd0);
      check_eq("rstfly_hazB", 32'(bus.hazard_B), 32'd0);
      check_eq("rstfly_tie", 32'(bus.req0_ready), 32'd1);
      step();

      // Randomized traffic; requesters hold while stalled
      for (int i = 0; i < 3000; i++) begin
         if (!(bus.req0_valid && !m_g0)) begin
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req0_addr  = 5'($urandom_range(0, 7));
            bus.req0_data  = $urandom;
         end
         if (!(bus.req1_valid && !m_g1)) begin
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req1_addr  = 5'($urandom_range(0, 7));
            bus.req1_data  = $urandom;
         end
         bus.iss_valid = ($urandom_range(0, 1) != 0);
         bus.iss_addr  = 5'($urandom_range(0, 7));
         bus.R_addr_A  = 5'($urandom_range(0, 7));
         bus.R_addr_B  = 5'($urandom_range(0, 7));
         rst           = ($urandom_range(0, 59) == 0);
         step();
      end
      rst = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
